// File: rtl/reset_pattern_checker_if.sv
// Signature-word bus between the reset-release signature source and its checker.
// The master side drives the monitored word; the slave (checker) drives the status.
interface reset_pattern_checker_if #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned CNT_W = 8
) ();
   logic [WIDTH-1:0] data_in;
   logic             locked;
   logic             fail;
   logic [2:0]       err_code;
   logic [CNT_W-1:0] latency;
   logic [CNT_W-1:0] stable_cnt;
   logic [WIDTH-1:0] bad_value;

   modport master (
      output data_in,
      input  locked, fail, err_code, latency, stable_cnt, bad_value
   );

   modport slave (
      input  data_in,
      output locked, fail, err_code, latency, stable_cnt, bad_value
   );
endinterface

// File: rtl/reset_pattern_checker.sv
// Checks that the signature word is cleared by reset, reaches EXPECTED within TIMEOUT
// cycles and then holds it; failures are sticky until the next reset.
module reset_pattern_checker #(
   parameter int unsigned      WIDTH    = 24,
   parameter logic [WIDTH-1:0] EXPECTED = 24'hC0FFEE,
   parameter int unsigned      TIMEOUT  = 4,
   parameter int unsigned      CNT_W    = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   reset_pattern_checker_if.slave  bus
);

   typedef enum logic [1:0] {StChkZero, StWait, StLocked, StFail} state_e;

   localparam logic [2:0] ErrNone       = 3'd0;
   localparam logic [2:0] ErrNotCleared = 3'd1;
   localparam logic [2:0] ErrBadValue   = 3'd2;
   localparam logic [2:0] ErrTimeout    = 3'd3;
   localparam logic [2:0] ErrDropout    = 3'd4;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             locked_q, locked_d;
   logic             fail_q, fail_d;
   logic [2:0]       err_q, err_d;
   logic [CNT_W-1:0] latency_q, latency_d;
   logic [CNT_W-1:0] stable_q, stable_d;
   logic [WIDTH-1:0] bad_q, bad_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      locked_d  = locked_q;
      fail_d    = fail_q;
      err_d     = err_q;
      latency_d = latency_q;
      stable_d  = stable_q;
      bad_d     = bad_q;

      unique case (state_q)
         StChkZero: begin
            if (bus.data_in != '0) begin
               state_d = StFail;
               fail_d  = 1'b1;
               err_d   = ErrNotCleared;
               bad_d   = bus.data_in;
            end else begin
               state_d = StWait;
               cnt_d   = CNT_W'(1);
            end
         end
         StWait: begin
            // Pattern match wins over the timeout on the last allowed cycle.
            if (bus.data_in == EXPECTED) begin
               state_d   = StLocked;
               latency_d = cnt_q;
               locked_d  = 1'b1;
               stable_d  = CNT_W'(1);
            end else if (bus.data_in != '0) begin
               state_d = StFail;
               fail_d  = 1'b1;
               err_d   = ErrBadValue;
               bad_d   = bus.data_in;
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               state_d = StFail;
               fail_d  = 1'b1;
               err_d   = ErrTimeout;
               bad_d   = bus.data_in;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StLocked: begin
            if (bus.data_in != EXPECTED) begin
               state_d  = StFail;
               fail_d   = 1'b1;
               err_d    = ErrDropout;
               bad_d    = bus.data_in;
               locked_d = 1'b0;
            end else if (stable_q != '1) begin
               stable_d = stable_q + CNT_W'(1);
            end
         end
         StFail: begin
            state_d = StFail;
         end
         default: begin
            state_d = StChkZero;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StChkZero;
         cnt_q     <= '0;
         locked_q  <= 1'b0;
         fail_q    <= 1'b0;
         err_q     <= ErrNone;
         latency_q <= '0;
         stable_q  <= '0;
         bad_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         locked_q  <= locked_d;
         fail_q    <= fail_d;
         err_q     <= err_d;
         latency_q <= latency_d;
         stable_q  <= stable_d;
         bad_q     <= bad_d;
      end
   end

   assign bus.locked     = locked_q;
   assign bus.fail       = fail_q;
   assign bus.err_code   = err_q;
   assign bus.latency    = latency_q;
   assign bus.stable_cnt = stable_q;
   assign bus.bad_value  = bad_q;

endmodule

// File: doc/reset_pattern_checker.md
Name: reset_pattern_checker

Overview:
- Receive-side monitor for the reset-release signature word. After rst_n deasserts, the upstream signature source drives zero and then a fixed pattern (default 24'hC0FFEE).
- This block samples that bus and checks, cycle by cycle, that it was cleared by reset, reaches the pattern within a bounded latency, and holds it thereafter.
- It reports pass/lock, a sticky fail with an error code, the measured latency and the offending value.
- It sits alongside the signature source on the same clk/rst_n and is used in bring-up and self-test.

Parameters:
- WIDTH, 24, width of monitored word.
- EXPECTED, 24'hC0FFEE, signature value required after reset.
- TIMEOUT, 4, max cycles after the zero check to reach EXPECTED; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of latency and stable counters.

Ports:
- clk, in, 1, single clock; all logic on posedge.
- rst_n, in, 1, reset, synchronous, active-low; shared with the monitored source.
- data_in, in, WIDTH, monitored signature word.
- locked, out, 1, high while in LOCKED.
- fail, out, 1, sticky failure flag.
- err_code, out, 3, 0=none, 1=NOT_CLEARED, 2=BAD_VALUE, 3=TIMEOUT, 4=DROPOUT.
- latency, out, CNT_W, cycles from the zero check to first EXPECTED.
- stable_cnt, out, CNT_W, saturating count of consecutive LOCKED cycles.
- bad_value, out, WIDTH, data_in captured on the failing cycle.

Behaviour:
- Reset: all state and outputs are registered. On any posedge with rst_n=0:
  - state<=CHK_ZERO, cnt<=0.
  - locked, fail, err_code, latency, stable_cnt and bad_value <=0.
  - Reset mid-operation (any state, including FAIL) aborts and restarts the check from CHK_ZERO.
- Reset takes priority over every other condition.
- States: CHK_ZERO, WAIT, LOCKED, FAIL. Each posedge with rst_n=1 evaluates data_in in the current state.
- CHK_ZERO (first posedge after release):
  - data_in!=0 -> FAIL, err_code=1, bad_value=data_in.
  - else -> WAIT, cnt<=1.
- WAIT, priority order:
  - data_in==EXPECTED -> LOCKED, latency<=cnt, locked<=1, stable_cnt<=1.
  - else data_in!=0 -> FAIL, err_code=2, bad_value=data_in.
  - else cnt==TIMEOUT -> FAIL, err_code=3, bad_value=data_in (0).
  - else cnt<=cnt+1.
- LOCKED:
  - data_in!=EXPECTED -> FAIL, err_code=4, bad_value=data_in, locked<=0.
  - else stable_cnt<=stable_cnt+1, saturating at 2^CNT_W-1 (no wrap).
- FAIL: absorbing.
  - fail=1; err_code, bad_value and latency hold.
  - latency holds its measured value if the failure was a DROPOUT, else stays 0.
  - stable_cnt freezes. Exit only via rst_n=0.
- Output timing: all outputs update on the same edge as the state transition, so a flag is visible one cycle after the sampled condition.
- Nominal source timing: release edge k samples 0 (-> WAIT); edge k+1 samples EXPECTED -> locked=1, latency=1 from edge k+1 onward.
- fail and locked are never both 1; err_code!=0 iff fail=1.
- EXPECTED==0 is unsupported; WAIT would lock on the first cycle.

Test Plan:
1. Nominal: rst_n low 3 cycles, release; data_in=0 for 1 cycle then 24'hC0FFEE held 10 cycles.
   -> locked=1 after edge k+1, latency=1, stable_cnt=10, fail=0, err_code=0.
2. Not cleared: data_in=24'h123456 on first post-release edge.
   -> fail=1, err_code=1, bad_value=24'h123456, locked=0; holds for 20 cycles.
3. Timeout: data_in held 0 after release.
   -> after zero check plus TIMEOUT=4 WAIT cycles: fail=1, err_code=3, bad_value=0, latency=0.
   Also: EXPECTED on the 4th WAIT cycle -> locked=1, latency=4.
4. Bad value / dropout:
   - WAIT sees 24'hC0FFEF -> err_code=2, bad_value=24'hC0FFEF.
   - Separate run: lock, then one cycle of 24'h000000 -> err_code=4, locked=0, latency=1 retained, stable_cnt frozen.
5. Reset mid-operation: assert rst_n=0 for 1 cycle while in LOCKED and, separately, while in FAIL.
   -> all outputs 0 on that edge; nominal sequence then re-locks with latency=1.
6. Saturation: CNT_W=4, hold EXPECTED 40 cycles.
   -> stable_cnt climbs to 15 and stays 15, locked remains 1.
